// File: rtl/axi_lite_datamem_bridge.sv
// AXI4-Lite slave in front of a single-port data memory. Buffers one AW, one W
// and one AR, then time-shares the memory port between writes and reads with
// round-robin arbitration. Writes become SB/SH/SW commands sized by WSTRB with
// the active lanes shifted down to bit 0; reads are always word loads.
module axi_lite_datamem_bridge #(
  parameter int MEM_ADDR_BITS = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [2:0]  mem_func3,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_e;

  typedef struct packed {
    logic        legal;
    logic [2:0]  func3;
    logic [1:0]  lsb;
    logic [31:0] data;
  } wr_cmd_t;

  // Map a byte-strobe pattern onto a memory store command with LSB-aligned data.
  function automatic wr_cmd_t decode_wstrb(input logic [3:0] strb, input logic [31:0] wdata);
    wr_cmd_t c;
    c.legal = 1'b1;
    c.func3 = 3'b010;
    c.lsb   = 2'b00;
    c.data  = wdata;
    case (strb)
      4'b1111: ;
      4'b0011: c.func3 = 3'b001;
      4'b1100: begin c.func3 = 3'b001; c.lsb = 2'b10; c.data = wdata >> 16; end
      4'b0001: c.func3 = 3'b000;
      4'b0010: begin c.func3 = 3'b000; c.lsb = 2'b01; c.data = wdata >> 8;  end
      4'b0100: begin c.func3 = 3'b000; c.lsb = 2'b10; c.data = wdata >> 16; end
      4'b1000: begin c.func3 = 3'b000; c.lsb = 2'b11; c.data = wdata >> 24; end
      default: c.legal = 1'b0;
    endcase
    return c;
  endfunction

  function automatic logic addr_in_range(input logic [31:0] a);
    logic [31:0] hi;
    hi = a >> MEM_ADDR_BITS;
    return (hi == 32'd0);
  endfunction

  state_e      state_q, state_d;
  logic        aw_held_q, aw_held_d, w_held_q, w_held_d, ar_held_q, ar_held_d;
  logic        last_was_write_q, last_was_write_d;
  logic        bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [2:0]  mem_func3_q, mem_func3_d;
  logic [31:0] aw_addr_q, aw_addr_d, w_data_q, w_data_d, ar_addr_q, ar_addr_d;
  logic [3:0]  w_strb_q, w_strb_d;

  logic        aw_fire, w_fire, ar_fire, wr_ok;
  wr_cmd_t     wr_cmd;

  // A pending B response frees the write channels in the cycle it is accepted.
  assign s_axi_awready = !aw_held_q && (!bvalid_q || s_axi_bready);
  assign s_axi_wready  = !w_held_q  && (!bvalid_q || s_axi_bready);
  assign s_axi_arready = !ar_held_q && !rvalid_q;

  assign aw_fire = s_axi_awvalid && s_axi_awready;
  assign w_fire  = s_axi_wvalid  && s_axi_wready;
  assign ar_fire = s_axi_arvalid && s_axi_arready;

  assign wr_cmd = decode_wstrb(w_strb_q, w_data_q);
  assign wr_ok  = wr_cmd.legal && addr_in_range(aw_addr_q);

  // Next-state: channel capture, response retirement and the arbitration FSM.
  always_comb begin
    state_d          = state_q;
    aw_held_d        = aw_held_q;
    w_held_d         = w_held_q;
    ar_held_d        = ar_held_q;
    last_was_write_d = last_was_write_q;
    bvalid_d         = bvalid_q;
    rvalid_d         = rvalid_q;
    bresp_d          = bresp_q;
    rresp_d          = rresp_q;
    rdata_d          = rdata_q;
    mem_we_d         = 1'b0;
    mem_func3_d      = 3'b010;
    mem_addr_d       = mem_addr_q;
    mem_wdata_d      = mem_wdata_q;
    aw_addr_d        = aw_addr_q;
    w_data_d         = w_data_q;
    w_strb_d         = w_strb_q;
    ar_addr_d        = ar_addr_q;

    if (aw_fire) begin
      aw_held_d = 1'b1;
      aw_addr_d = s_axi_awaddr;
    end
    if (w_fire) begin
      w_held_d = 1'b1;
      w_data_d = s_axi_wdata;
      w_strb_d = s_axi_wstrb;
    end
    if (ar_fire) begin
      ar_held_d = 1'b1;
      ar_addr_d = s_axi_araddr;
    end
    if (bvalid_q && s_axi_bready) bvalid_d = 1'b0;
    if (rvalid_q && s_axi_rready) rvalid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // On a tie the side that did not go last wins.
        if (aw_held_q && w_held_q && (!ar_held_q || !last_was_write_q)) begin
          state_d  = ST_WRITE;
          mem_we_d = wr_ok;
          if (wr_ok) begin
            mem_func3_d = wr_cmd.func3;
            mem_addr_d  = {aw_addr_q[31:2], wr_cmd.lsb};
            mem_wdata_d = wr_cmd.data;
          end
        end else if (ar_held_q) begin
          state_d    = ST_READ;
          mem_addr_d = {ar_addr_q[31:2], 2'b00};
        end
      end
      ST_WRITE: begin
        state_d          = ST_IDLE;
        aw_held_d        = 1'b0;
        w_held_d         = 1'b0;
        bvalid_d         = 1'b1;
        bresp_d          = wr_ok ? 2'b00 : 2'b10;
        last_was_write_d = 1'b1;
      end
      ST_READ: begin
        state_d          = ST_IDLE;
        ar_held_d        = 1'b0;
        rvalid_d         = 1'b1;
        last_was_write_d = 1'b0;
        if (addr_in_range(ar_addr_q)) begin
          rdata_d = mem_rdata;
          rresp_d = 2'b00;
        end else begin
          rdata_d = 32'd0;
          rresp_d = 2'b10;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and visible outputs; reset aborts any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      aw_held_q        <= 1'b0;
      w_held_q         <= 1'b0;
      ar_held_q        <= 1'b0;
      last_was_write_q <= 1'b0;
      bvalid_q         <= 1'b0;
      rvalid_q         <= 1'b0;
      bresp_q          <= 2'b00;
      rresp_q          <= 2'b00;
      rdata_q          <= 32'd0;
      mem_we_q         <= 1'b0;
      mem_func3_q      <= 3'b010;
      mem_addr_q       <= 32'd0;
      mem_wdata_q      <= 32'd0;
    end else begin
      state_q          <= state_d;
      aw_held_q        <= aw_held_d;
      w_held_q         <= w_held_d;
      ar_held_q        <= ar_held_d;
      last_was_write_q <= last_was_write_d;
      bvalid_q         <= bvalid_d;
      rvalid_q         <= rvalid_d;
      bresp_q          <= bresp_d;
      rresp_q          <= rresp_d;
      rdata_q          <= rdata_d;
      mem_we_q         <= mem_we_d;
      mem_func3_q      <= mem_func3_d;
      mem_addr_q       <= mem_addr_d;
      mem_wdata_q      <= mem_wdata_d;
    end
  end

  // Channel payloads are only meaningful while their held flag is set.
  always_ff @(posedge clk) begin
    aw_addr_q <= aw_addr_d;
    w_data_q  <= w_data_d;
    w_strb_q  <= w_strb_d;
    ar_addr_q <= ar_addr_d;
  end

  assign s_axi_bvalid = bvalid_q;
  assign s_axi_bresp  = bresp_q;
  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rresp  = rresp_q;
  assign s_axi_rdata  = rdata_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_func3    = mem_func3_q;
  assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_axi_lite_datamem_bridge.sv
// Scoreboard bench: stimulus pushes expected B/R responses and memory commands,
// monitors pop and compare when the DUT presents them.
module tb_axi_lite_datamem_bridge;

  logic        clk, rst_n;
  logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [3:0]  s_axi_wstrb;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rvalid, s_axi_rready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [2:0]  mem_func3;

  axi_lite_datamem_bridge #(.MEM_ADDR_BITS(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_func3(mem_func3),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  typedef struct {logic [31:0] data; logic [1:0] resp;} rsp_t;
  typedef struct {logic [31:0] addr; logic [2:0] func3; logic [31:0] data;} mcmd_t;

  logic [1:0] exp_b[$];
  rsp_t       exp_r[$];
  mcmd_t      exp_m[$];
  logic [7:0] dmem [0:4095];
  logic [7:0] ref_mem [0:4095];
  int         checks = 0, passes = 0;
  int         bmode = 2, rmode = 0;
  logic [3:0] legal_strb [7] = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};

  initial begin clk = 0; forever #5 clk = ~clk; end

  initial begin #500000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

  // Memory behind the bridge: combinational word read, sized write on the edge.
  assign mem_rdata = {dmem[{mem_addr[11:2], 2'd3}], dmem[{mem_addr[11:2], 2'd2}],
                      dmem[{mem_addr[11:2], 2'd1}], dmem[{mem_addr[11:2], 2'd0}]};
  initial begin
    for (int i = 0; i < 4096; i++) dmem[i] = 8'(i * 37 + 5);
    forever begin
      @(posedge clk);
      if (mem_we) begin
        case (mem_func3)
          3'b000: dmem[mem_addr[11:0]] = mem_wdata[7:0];
          3'b001: begin
            dmem[{mem_addr[11:1], 1'b0}] = mem_wdata[7:0];
            dmem[{mem_addr[11:1], 1'b1}] = mem_wdata[15:8];
          end
          3'b010: for (int k = 0; k < 4; k++) dmem[{mem_addr[11:2], 2'(k)}] = mem_wdata[8*k +: 8];
          default: ;
        endcase
      end
    end
  end

  // Ready generators: 0 = always ready, 1 = random, 2 = held low.
  initial begin
    s_axi_bready = 0; s_axi_rready = 1;
    forever begin
      @(posedge clk); #1;
      s_axi_bready = (bmode == 0) ? 1'b1 : (bmode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
      s_axi_rready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: got timeout/unexpected expected event", name);
  endtask

  // Monitor: compare whatever the DUT presents against the queued expectations.
  always @(negedge clk) begin
    if (rst_n) begin
      if (s_axi_bvalid && s_axi_bready) begin
        if (exp_b.size() == 0) fail_now("unexpected_b");
        else chk("bresp", 32'(s_axi_bresp), 32'(exp_b.pop_front()));
      end
      if (s_axi_rvalid && s_axi_rready) begin
        if (exp_r.size() == 0) fail_now("unexpected_r");
        else begin
          rsp_t r;
          r = exp_r.pop_front();
          chk("rdata", s_axi_rdata, r.data);
          chk("rresp", 32'(s_axi_rresp), 32'(r.resp));
        end
      end
      if (mem_we) begin
        if (exp_m.size() == 0) fail_now("unexpected_mem_we");
        else begin
          mcmd_t m;
          m = exp_m.pop_front();
          chk("mem_addr", mem_addr, m.addr);
          chk("mem_func3", 32'(mem_func3), 32'(m.func3));
          chk("mem_wdata", mem_wdata, m.data);
        end
      end
    end
  end

  // Reference model: lane-wise byte writes into ref_mem, responses from the rules.
  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic legal, inr;
    int   lsb, cnt;
    mcmd_t m;
    cnt   = $countones(s);
    legal = (s == 4'hF) || (s == 4'h3) || (s == 4'hC) || (cnt == 1);
    inr   = (a < 32'h1000);
    if (legal && inr) begin
      lsb = 0;
      for (int k = 3; k >= 0; k--) if (s[k]) lsb = k;
      m.addr  = (a & 32'hFFFF_FFFC) + 32'(lsb);
      m.func3 = (cnt == 1) ? 3'b000 : (cnt == 2) ? 3'b001 : 3'b010;
      m.data  = d >> (8 * lsb);
      exp_m.push_back(m);
      for (int k = 0; k < 4; k++) if (s[k]) ref_mem[int'(a & 32'hFFC) + k] = d[8*k +: 8];
      exp_b.push_back(2'b00);
    end else begin
      exp_b.push_back(2'b10);
    end
  endtask

  task automatic model_read(input logic [31:0] a);
    rsp_t r;
    int   b;
    if (a < 32'h1000) begin
      b = int'(a & 32'hFFC);
      r.data = {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
      r.resp = 2'b00;
    end else begin
      r.data = 32'd0;
      r.resp = 2'b10;
    end
    exp_r.push_back(r);
  endtask

  // Channel drivers: start and end at 1 time unit after a rising edge.
  task automatic drive_aw(input logic [31:0] a, input int dly);
    int n = 0;
    repeat (dly) @(posedge clk);
    if (dly > 0) #1;
    s_axi_awaddr = a; s_axi_awvalid = 1;
    forever begin
      @(negedge clk);
      if (s_axi_awready) break;
      if (++n > 100) begin fail_now("aw_timeout"); break; end
    end
    @(posedge clk); #1 s_axi_awvalid = 0;
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    int n = 0;
    repeat (dly) @(posedge clk);
    if (dly > 0) #1;
    s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1;
    forever begin
      @(negedge clk);
      if (s_axi_wready) break;
      if (++n > 100) begin fail_now("w_timeout"); break; end
    end
    @(posedge clk); #1 s_axi_wvalid = 0;
  endtask

  task automatic drive_ar(input logic [31:0] a, input int dly);
    int n = 0;
    repeat (dly) @(posedge clk);
    if (dly > 0) #1;
    s_axi_araddr = a; s_axi_arvalid = 1;
    forever begin
      @(negedge clk);
      if (s_axi_arready) break;
      if (++n > 100) begin fail_now("ar_timeout"); break; end
    end
    @(posedge clk); #1 s_axi_arvalid = 0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (exp_b.size() != 0 || exp_r.size() != 0 || exp_m.size() != 0) begin
      @(posedge clk); #1;
      if (++n > 200) begin
        fail_now(name);
        exp_b.delete(); exp_r.delete(); exp_m.delete();
        break;
      end
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int aw_dly, input int w_dly);
    model_write(a, d, s);
    fork
      drive_aw(a, aw_dly);
      drive_w(d, s, w_dly);
    join
    wait_idle("write_response_timeout");
  endtask

  task automatic rd(input logic [31:0] a, input int dly);
    model_read(a);
    drive_ar(a, dly);
    wait_idle("read_response_timeout");
  endtask

  task automatic tick; @(posedge clk); #1; endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  s;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'(i * 37 + 5);
    rst_n = 0;
    s_axi_awaddr = 0; s_axi_awvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wvalid = 0;
    s_axi_araddr = 0; s_axi_arvalid = 0;
    repeat (3) tick();
    chk("rst_awready", 32'(s_axi_awready), 32'd1);
    chk("rst_wready", 32'(s_axi_wready), 32'd1);
    chk("rst_arready", 32'(s_axi_arready), 32'd1);
    chk("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
    chk("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
    chk("rst_bresp", 32'(s_axi_bresp), 32'd0);
    chk("rst_rresp", 32'(s_axi_rresp), 32'd0);
    chk("rst_rdata", s_axi_rdata, 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_func3", 32'(mem_func3), 32'd2);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1;
    tick();

    // Same-cycle AW+W word write with exact latency, bready held low afterwards.
    model_write(32'h10, 32'hDEADBEEF, 4'hF);
    s_axi_awaddr = 32'h10; s_axi_awvalid = 1;
    s_axi_wdata = 32'hDEADBEEF; s_axi_wstrb = 4'hF; s_axi_wvalid = 1;
    tick();
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    chk("lat_e0_mem_we", 32'(mem_we), 32'd0);
    tick();
    chk("lat_e1_mem_we", 32'(mem_we), 32'd1);
    chk("lat_e1_bvalid", 32'(s_axi_bvalid), 32'd0);
    tick();
    chk("lat_e2_bvalid", 32'(s_axi_bvalid), 32'd1);
    chk("lat_e2_mem_we", 32'(mem_we), 32'd0);
    model_read(32'h10);
    s_axi_araddr = 32'h10; s_axi_arvalid = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) s_axi_arvalid = 0;
      chk("hold_bvalid", 32'(s_axi_bvalid), 32'd1);
      chk("hold_bresp", 32'(s_axi_bresp), 32'd0);
      chk("hold_awready", 32'(s_axi_awready), 32'd0);
      chk("hold_wready", 32'(s_axi_wready), 32'd0);
      if (i < 2) chk("rd_lat_early_rvalid", 32'(s_axi_rvalid), 32'd0);
      if (i == 2) chk("rd_lat_e2_rvalid", 32'(s_axi_rvalid), 32'd1);
    end
    bmode = 0;
    wait_idle("hold_test_timeout");

    // Sized writes and error responses with randomised readiness.
    bmode = 1; rmode = 1;
    wr(32'h21, 32'h0000AB00, 4'b0010, 3, 0);
    rd(32'h20, 1);
    wr(32'h40, 32'h12340000, 4'b1100, 0, 2);
    rd(32'h40, 0);
    wr(32'h0, 32'hCAFEF00D, 4'b0110, 0, 0);
    rd(32'h1000, 0);
    wr(32'h2000, 32'h11223344, 4'hF, 1, 0);
    rd(32'h0, 0);

    // Arbitration ties: first tie after reset goes to the write.
    bmode = 0; rmode = 0;
    rst_n = 0; tick(); rst_n = 1; tick();
    model_write(32'h80, 32'hA5A5_0001, 4'hF);
    model_read(32'h90);
    s_axi_awaddr = 32'h80; s_axi_awvalid = 1; s_axi_wdata = 32'hA5A5_0001; s_axi_wstrb = 4'hF;
    s_axi_wvalid = 1; s_axi_araddr = 32'h90; s_axi_arvalid = 1;
    tick();
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
    tick();
    chk("tie1_write_first", 32'(mem_we), 32'd1);
    tick();
    chk("tie1_e2_bvalid", 32'(s_axi_bvalid), 32'd1);
    chk("tie1_e2_rvalid", 32'(s_axi_rvalid), 32'd0);
    tick(); tick();
    chk("tie1_e4_rvalid", 32'(s_axi_rvalid), 32'd1);
    wait_idle("tie1_timeout");
    wr(32'hA0, 32'h0BAD_CAFE, 4'hF, 0, 0);
    model_read(32'h94);
    model_write(32'h84, 32'h5A5A_0002, 4'hF);
    s_axi_awaddr = 32'h84; s_axi_awvalid = 1; s_axi_wdata = 32'h5A5A_0002; s_axi_wstrb = 4'hF;
    s_axi_wvalid = 1; s_axi_araddr = 32'h94; s_axi_arvalid = 1;
    tick();
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
    tick();
    chk("tie2_read_first_we", 32'(mem_we), 32'd0);
    tick();
    chk("tie2_e2_rvalid", 32'(s_axi_rvalid), 32'd1);
    chk("tie2_e2_bvalid", 32'(s_axi_bvalid), 32'd0);
    tick();
    chk("tie2_e3_mem_we", 32'(mem_we), 32'd1);
    tick();
    chk("tie2_e4_bvalid", 32'(s_axi_bvalid), 32'd1);
    wait_idle("tie2_timeout");

    // Reset during WRITE aborts the store and the response.
    s_axi_awaddr = 32'h100; s_axi_awvalid = 1; s_axi_wdata = 32'h55AA55AA; s_axi_wstrb = 4'hF;
    s_axi_wvalid = 1;
    tick();
    s_axi_awvalid = 0; s_axi_wvalid = 0;
    tick();
    chk("abort_write_state_we", 32'(mem_we), 32'd1);
    #1 rst_n = 0;
    #1;
    chk("abort_mem_we_drop", 32'(mem_we), 32'd0);
    chk("abort_bvalid", 32'(s_axi_bvalid), 32'd0);
    tick(); tick();
    chk("abort_bvalid_later", 32'(s_axi_bvalid), 32'd0);
    rst_n = 1;
    tick();
    chk("abort_awready", 32'(s_axi_awready), 32'd1);
    rd(32'h100, 0);

    // Randomised sequential traffic against the reference model.
    bmode = 1; rmode = 1;
    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 4095));
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom;
        s = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : legal_strb[$urandom_range(0, 6)];
        wr(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3));
      end else begin
        rd(a, $urandom_range(0, 2));
      end
    end

    repeat (3) tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
